mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous RAM (`ram`: `d`, `ad`, `we`, `q`, `clk`; `q` valid the cycle after `ad` is presented) between two requesters.
  - Instruction-fetch port: read-only.
  - Data load/store port: read and write.
- Sits in `cpu` between the fetch/LSU logic and a unified `ram` instance.
- Arbitration is round-robin on contention. Accesses are fully pipelined: one grant per cycle and a fixed 1-cycle response latency.

Parameters:
- ADDR_W, 32, address width of both ports and the RAM.
- DATA_W, 32, data width of both ports and the RAM.

Ports:
- clk  in  1  system clock, rising edge
- nreset  in  1  asynchronous active-low reset
- i_req  in  1  fetch request, level, held until granted
- i_addr  in  ADDR_W  fetch address
- i_gnt  out  1  fetch request accepted this cycle
- i_rvalid  out  1  fetch data valid (cycle after i_gnt)
- i_rdata  out  DATA_W  fetch read data
- d_req  in  1  data request, level, held until granted
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  load data valid or store ack (cycle after d_gnt)
- d_rdata  out  DATA_W  load read data
- mem_ad  out  ADDR_W  to `ram.ad`
- mem_d  out  DATA_W  to `ram.d`
- mem_we  out  1  to `ram.we`
- mem_q  in  DATA_W  from `ram.q`

Behaviour:

Interface
- Single clock `clk`.
- Reset `nreset` is asynchronous, active-low. All registers clear immediately on assertion.

Arbitration (combinational from req and last_winner)
- Only one requester asserts req: it is granted.
- Both assert req: grant goes to the port that is NOT last_winner.
- Neither asserts req: no grant.
- last_winner register:
  - Updates only on contention cycles (both requesting).
  - Resets to INSTR, so data wins the first contention.
- At most one of i_gnt/d_gnt is high in any cycle.
- Requesters must hold req, addr, we and wdata stable until gnt. The block does not latch ungranted requests.

Memory drive (combinational)
- mem_ad = d_gnt ? d_addr : i_addr (i_addr also when idle).
- mem_d = d_wdata.
- mem_we = d_gnt & d_we.

Response registers (reset 0)
- rsp_i <= i_gnt.
- rsp_d <= d_gnt.
- rsp_rd <= d_gnt & ~d_we.
- i_rvalid = rsp_i.
- d_rvalid = rsp_d (pulses for both loads and stores).

Read data hold
- Registers hold_i and hold_d, reset 0.
- i_rdata = rsp_i ? mem_q : hold_i. hold_i <= mem_q when rsp_i.
- d_rdata = rsp_rd ? mem_q : hold_d. hold_d <= mem_q when rsp_rd.
- A store ack leaves d_rdata at the previous load value.

Reset values
- All gnt and rvalid outputs: 0.
- rdata outputs: 0.
- mem_we: 0.
- mem_ad: follows i_addr.

Throughput and latency
- Back-to-back grants every cycle, no bubbles.
- Response always arrives exactly 1 cycle after its grant, in grant order.

Boundary conditions
- Reset asserted mid-access: the outstanding response is dropped. No rvalid after reset release.
- Continuous contention: strict alternation d, i, d, i, … No starvation; worst-case wait is 1 cycle.
- Store followed by load to the same address on consecutive cycles: the load returns the new data (RAM write-then-read ordering).
- Requester deasserts req without a grant: the request is legal and simply lost.

Test Plan:
- Reset, then idle → all gnt/rvalid 0, i_rdata = d_rdata = 0, mem_we = 0. Assert nreset low mid-stream → outputs 0 the same cycle with no clock edge, and no rvalid follows.
- RAM preloaded with [0x10] = 0xDEADBEEF. Hold i_req = 1, i_addr = 0x10 for 1 cycle → i_gnt = 1 that cycle; next cycle i_rvalid = 1, i_rdata = 0xDEADBEEF; i_rdata holds 0xDEADBEEF after i_rvalid drops.
- d_req = 1, d_we = 1, d_addr = 0x20, d_wdata = 0x12345678, then d_we = 0 load of 0x20 → store ack d_rvalid with d_rdata unchanged; load returns 0x12345678 the cycle after its grant.
- Both req held high for 6 cycles from reset → grant sequence d, i, d, i, d, i. rvalid pulses alternate accordingly, one cycle later.
- i_req held continuously while d_req pulses every 3rd cycle → the data request is granted within 1 cycle of asserting. i_gnt drops only in those cycles. Fetch rdata matches a RAM model.
- Random mixed traffic for 10k cycles, checked against a reference memory model → every granted read returns the correct data at grant+1; never both gnt high; mem_we only with d_gnt & d_we.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-port front end (fetch read-only, data read/write) onto one single-port synchronous RAM.
// Round-robin on contention, one grant per cycle, response exactly one cycle after grant.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_ad,
  output logic [DATA_W-1:0] mem_d,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_q
);

  typedef enum logic {
    WIN_INSTR = 1'b0,
    WIN_DATA  = 1'b1
  } winner_t;

  winner_t           last_winner;
  logic              contention;
  logic              rsp_i;
  logic              rsp_d;
  logic              rsp_rd;
  logic [DATA_W-1:0] hold_i;
  logic [DATA_W-1:0] hold_d;

  // On contention the side that did not win last time gets the slot.
  assign contention = i_req & d_req;
  assign d_gnt      = d_req & (~i_req | (last_winner == WIN_INSTR));
  assign i_gnt      = i_req & ~d_gnt;

  assign mem_ad = d_gnt ? d_addr : i_addr;
  assign mem_d  = d_wdata;
  assign mem_we = d_gnt & d_we;

  assign i_rvalid = rsp_i;
  assign d_rvalid = rsp_d;
  assign i_rdata  = rsp_i  ? mem_q : hold_i;
  assign d_rdata  = rsp_rd ? mem_q : hold_d;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      last_winner <= WIN_INSTR;
      rsp_i       <= 1'b0;
      rsp_d       <= 1'b0;
      rsp_rd      <= 1'b0;
      hold_i      <= '0;
      hold_d      <= '0;
    end else begin
      if (contention) begin
        last_winner <= d_gnt ? WIN_DATA : WIN_INSTR;
      end
      rsp_i  <= i_gnt;
      rsp_d  <= d_gnt;
      rsp_rd <= d_gnt & ~d_we;
      // Store acks leave the last load value visible on d_rdata.
      if (rsp_i) begin
        hold_i <= mem_q;
      end
      if (rsp_rd) begin
        hold_d <= mem_q;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: behavioural RAM, per-cycle reference model, directed literal checks.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk     = 1'b0;
  logic          nreset  = 1'b0;
  logic          i_req   = 1'b0;
  logic [AW-1:0] i_addr  = '0;
  logic          d_req   = 1'b0;
  logic          d_we    = 1'b0;
  logic [AW-1:0] d_addr  = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          i_gnt, i_rvalid, d_gnt, d_rvalid, mem_we;
  logic [DW-1:0] i_rdata, d_rdata, mem_d, mem_q;
  logic [AW-1:0] mem_ad;

  int n_cmp = 0;
  int n_bad = 0;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .nreset(nreset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_ad(mem_ad), .mem_d(mem_d), .mem_we(mem_we), .mem_q(mem_q)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int k);
    if (k == 16) return 32'hDEADBEEF;
    return {8'(k), ~8'(k), 8'hA5, 8'(k)};
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Single-port RAM: write and registered read on the same edge, 256 words.
  logic [DW-1:0] ram_mem [256];
  logic          ram_loaded = 1'b0;
  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int k = 0; k < 256; k++) ram_mem[k] <= init_word(k);
      ram_loaded <= 1'b1;
    end else if (mem_we) begin
      ram_mem[mem_ad[7:0]] <= mem_d;
    end
    mem_q <= ram_mem[mem_ad[7:0]];
  end

  // Reference model: memory contents as seen in grant order plus one pending response per port.
  logic [DW-1:0] mm [256];
  bit            d_turn = 1'b1;
  bit            pend_i = 1'b0, pend_d = 1'b0, pend_rd = 1'b0;
  logic [DW-1:0] pd_i = '0, pd_d = '0, held_i = '0, held_d = '0;

  initial begin : model
    bit eg_i, eg_d;
    forever begin
      @(negedge clk);
      if (!nreset) begin
        chk1("m_rst_i_rvalid", i_rvalid, 1'b0);
        chk1("m_rst_d_rvalid", d_rvalid, 1'b0);
        chk32("m_rst_i_rdata", i_rdata, 32'h0);
        chk32("m_rst_d_rdata", d_rdata, 32'h0);
        chk1("m_rst_mem_we", mem_we, 1'b0);
        d_turn = 1'b1; pend_i = 1'b0; pend_d = 1'b0; pend_rd = 1'b0;
        held_i = '0; held_d = '0;
      end else begin
        if (i_req && d_req) begin
          eg_d = d_turn; eg_i = !d_turn; d_turn = !d_turn;
        end else begin
          eg_d = d_req; eg_i = i_req;
        end
        chk1("m_i_gnt", i_gnt, eg_i);
        chk1("m_d_gnt", d_gnt, eg_d);
        chk1("m_mem_we", mem_we, eg_d && d_we);
        chk32("m_mem_ad", mem_ad, eg_d ? d_addr : i_addr);
        chk32("m_mem_d", mem_d, d_wdata);
        chk1("m_i_rvalid", i_rvalid, pend_i);
        chk1("m_d_rvalid", d_rvalid, pend_d);
        chk32("m_i_rdata", i_rdata, pend_i ? pd_i : held_i);
        chk32("m_d_rdata", d_rdata, pend_rd ? pd_d : held_d);
        if (pend_i) held_i = pd_i;
        if (pend_rd) held_d = pd_d;
        pend_i = eg_i; pend_d = eg_d; pend_rd = eg_d && !d_we;
        if (eg_i) pd_i = mm[i_addr[7:0]];
        if (eg_d) begin
          pd_d = mm[d_addr[7:0]];
          if (d_we) mm[d_addr[7:0]] = d_wdata;
        end
      end
    end
  end

  task automatic do_reset();
    nreset = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    repeat (2) @(posedge clk);
    #1 nreset = 1'b1;
  endtask

  initial begin : stim
    bit ig, dg;
    int wait_c;
    for (int k = 0; k < 256; k++) mm[k] = init_word(k);

    // Reset state and idle
    repeat (2) @(posedge clk);
    #1;
    chk1("rst_i_gnt", i_gnt, 1'b0);
    chk1("rst_d_rvalid", d_rvalid, 1'b0);
    chk32("rst_i_rdata", i_rdata, 32'h0);
    nreset = 1'b1; i_addr = 32'h33;
    @(negedge clk);
    chk32("idle_mem_ad", mem_ad, 32'h33);
    chk1("idle_mem_we", mem_we, 1'b0);
    chk32("idle_d_rdata", d_rdata, 32'h0);

    // Single fetch of preloaded word
    @(posedge clk); #1 i_req = 1'b1; i_addr = 32'h10;
    @(negedge clk); chk1("fetch_gnt", i_gnt, 1'b1);
    @(posedge clk); #1 i_req = 1'b0;
    @(negedge clk);
    chk1("fetch_rvalid", i_rvalid, 1'b1);
    chk32("fetch_rdata", i_rdata, 32'hDEADBEEF);
    @(posedge clk); #1;
    @(negedge clk);
    chk1("fetch_rvalid_drop", i_rvalid, 1'b0);
    chk32("fetch_rdata_hold", i_rdata, 32'hDEADBEEF);

    // Store then load of the same address on consecutive cycles
    @(posedge clk); #1 d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h12345678;
    @(negedge clk);
    chk1("st_gnt", d_gnt, 1'b1);
    chk1("st_mem_we", mem_we, 1'b1);
    @(posedge clk); #1 d_we = 1'b0;
    @(negedge clk);
    chk1("st_ack", d_rvalid, 1'b1);
    chk32("st_ack_rdata", d_rdata, 32'h0);
    chk1("ld_mem_we", mem_we, 1'b0);
    @(posedge clk); #1 d_req = 1'b0;
    @(negedge clk);
    chk1("ld_rvalid", d_rvalid, 1'b1);
    chk32("ld_rdata", d_rdata, 32'h12345678);

    // Reset asserted with a fetch response outstanding
    @(posedge clk); #1 i_req = 1'b1; i_addr = 32'h10;
    @(posedge clk); #1 i_req = 1'b0;
    chk1("pre_rst_rvalid", i_rvalid, 1'b1);
    nreset = 1'b0;
    #1;
    chk1("async_rst_rvalid", i_rvalid, 1'b0);
    chk32("async_rst_i_rdata", i_rdata, 32'h0);
    chk32("async_rst_d_rdata", d_rdata, 32'h0);
    @(posedge clk); #1 nreset = 1'b1;
    @(negedge clk);
    chk1("post_rst_i_rvalid", i_rvalid, 1'b0);
    chk1("post_rst_d_rvalid", d_rvalid, 1'b0);

    // Continuous contention from reset: d, i, d, i, d, i
    do_reset();
    i_req = 1'b1; d_req = 1'b1; d_we = 1'b0; i_addr = 32'h1; d_addr = 32'h2;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk1("rr_d_gnt", d_gnt, (k % 2) == 0);
      chk1("rr_i_gnt", i_gnt, (k % 2) == 1);
      @(posedge clk); #1;
      if ((k % 2) == 0) d_addr = 32'(k + 3);
      else i_addr = 32'(k + 3);
    end
    i_req = 1'b0; d_req = 1'b0;
    @(posedge clk); #1;

    // Fetch streaming while data requests arrive every third cycle
    i_req = 1'b1; i_addr = 32'($urandom_range(0, 255)); wait_c = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      ig = i_gnt; dg = d_gnt;
      if (d_req) begin
        if (dg) begin
          chk1("d_wait_le1", wait_c <= 1, 1'b1);
          wait_c = 0;
        end else begin
          wait_c++;
        end
      end
      @(posedge clk); #1;
      if (ig) i_addr = 32'($urandom_range(0, 255));
      if (d_req && dg) d_req = 1'b0;
      if ((c % 3) == 2 && !d_req) begin
        d_req = 1'b1; d_we = 1'($urandom_range(0, 1));
        d_addr = 32'($urandom_range(0, 255)); d_wdata = $urandom;
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    @(posedge clk); #1;

    // Mixed random traffic, including requests withdrawn before grant
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      ig = i_gnt; dg = d_gnt;
      @(posedge clk); #1;
      if (!i_req || ig) begin
        i_req = ($urandom_range(0, 3) != 0);
        i_addr = 32'($urandom_range(0, 255));
      end else if ($urandom_range(0, 31) == 0) begin
        i_req = 1'b0;
      end
      if (!d_req || dg) begin
        d_req = ($urandom_range(0, 2) != 0);
        d_we = 1'($urandom_range(0, 1));
        d_addr = 32'($urandom_range(0, 255));
        d_wdata = $urandom;
      end else if ($urandom_range(0, 31) == 0) begin
        d_req = 1'b0;
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
